// File: rtl/alu_seq_n_bit.sv
// Clocked WIDTH-bit ALU with valid/ready handshake, persistent carry flag and a
// bit-serial rotate-through-carry. Define ALU_OVF_EN to add the registered overflow flag vf.
module alu_seq_n_bit #(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             sf,
  output logic             zf
`ifdef ALU_OVF_EN
  ,
  output logic             vf
`endif
);

  typedef enum logic {IDLE, ROT} state_t;
  typedef enum logic [2:0] {
    OP_OR, OP_ADD, OP_ROL, OP_SUB, OP_AND, OP_XOR, OP_ZERO6, OP_ZERO7
  } op_t;

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t             state, state_n;
  logic [WIDTH-1:0]   w, w_n;
  logic               wcarry, wcarry_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [WIDTH:0]     sum, diff;
  logic [CNT_W-1:0]   rot_n;
  logic [WIDTH-1:0]   step_w;
  logic               step_c;

  logic               commit;
  logic [WIDTH-1:0]   res;
  logic               res_cf;
  logic               res_zero_op;
`ifdef ALU_OVF_EN
  logic               res_vf;
`endif

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign rot_n  = (b > WIDTH_V) ? CNT_W'(WIDTH) : CNT_W'(b);
  // One left step of the WIDTH+1-bit ring {wcarry, w}.
  assign step_w = {w[WIDTH-2:0], wcarry};
  assign step_c = w[M];

  assign in_ready = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    w_n         = w;
    wcarry_n    = wcarry;
    cnt_n       = cnt;
    commit      = 1'b0;
    res         = '0;
    res_cf      = cf;
    res_zero_op = 1'b0;
`ifdef ALU_OVF_EN
    res_vf      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          commit = 1'b1;
          case (op_t'(op))
            OP_OR:  begin res = a | b; res_cf = 1'b0; end
            OP_AND: begin res = a & b; res_cf = 1'b0; end
            OP_XOR: begin res = a ^ b; res_cf = 1'b0; end
            OP_ADD: begin
              res    = sum[M:0];
              res_cf = sum[WIDTH];
`ifdef ALU_OVF_EN
              res_vf = (a[M] == b[M]) && (sum[M] != a[M]);
`endif
            end
            OP_SUB: begin
              res    = diff[M:0];
              res_cf = diff[WIDTH];
`ifdef ALU_OVF_EN
              res_vf = (a[M] != b[M]) && (diff[M] != a[M]);
`endif
            end
            OP_ROL: begin
              if (rot_n == '0) begin
                res = a;
              end else begin
                // Multi-cycle rotate: hold results until the last step commits.
                commit   = 1'b0;
                w_n      = a;
                wcarry_n = cf;
                cnt_n    = rot_n;
                state_n  = ROT;
              end
            end
            default: begin
              res         = '0;
              res_cf      = 1'b0;
              res_zero_op = 1'b1;
            end
          endcase
        end
      end
      ROT: begin
        w_n      = step_w;
        wcarry_n = step_c;
        cnt_n    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit  = 1'b1;
          res     = step_w;
          res_cf  = step_c;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      wcarry    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      r         <= '0;
      cf        <= 1'b0;
      sf        <= 1'b0;
      zf        <= 1'b0;
`ifdef ALU_OVF_EN
      vf        <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      w         <= w_n;
      wcarry    <= wcarry_n;
      cnt       <= cnt_n;
      out_valid <= commit;
      if (commit) begin
        r  <= res;
        cf <= res_cf;
        // ZERO deliberately reports zf=0 to match the legacy ALU.
        sf <= res_zero_op ? 1'b0 : res[M];
        zf <= !res_zero_op && (res == '0);
`ifdef ALU_OVF_EN
        vf <= res_vf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n_bit.sv
// Directed self-checking bench for alu_seq_n_bit at WIDTH=6 (covers vf when ALU_OVF_EN is defined).
module tb_alu_seq_n_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic [5:0] r;
  logic       cf, sf, zf;
`ifdef ALU_OVF_EN
  logic       vf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] OR_ = 3'd0, ADD = 3'd1, ROL = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, XOR_ = 3'd5, ZERO6 = 3'd6, ZERO7 = 3'd7;

  alu_seq_n_bit #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .r(r),
    .cf(cf), .sf(sf), .zf(zf)
`ifdef ALU_OVF_EN
    , .vf(vf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one cycle; returns in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [5:0] av, input logic [5:0] bv);
    in_valid = 1'b1; op = o; a = av; b = bv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [5:0] er, input logic ec,
                           input logic es, input logic ez);
    check({tag, ".ov"}, out_valid, 1'b1);
    check({tag, ".r"},  r,  er);
    check({tag, ".cf"}, cf, ec);
    check({tag, ".sf"}, sf, es);
    check({tag, ".zf"}, zf, ez);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check("rst.r", r, 6'h00);
    check("rst.flags", {cf, sf, zf}, 3'b000);
    check("rst.ov", out_valid, 1'b0);
    check("rst.rdy", in_ready, 1'b1);
`ifdef ALU_OVF_EN
    check("rst.vf", vf, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // ADD with carry out to zero
    issue(ADD, 6'h3F, 6'h01);
    check_res("add_wrap", 6'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check("add_wrap.pulse_end", out_valid, 1'b0);
    check("add_wrap.hold", r, 6'h00);

    // SUB with borrow, then ADD clearing cf
    issue(SUB, 6'h05, 6'h07);
    check_res("sub_borrow", 6'h3E, 1'b1, 1'b1, 1'b0);
    issue(ADD, 6'h01, 6'h01);
    check_res("add_small", 6'h02, 1'b0, 1'b0, 1'b0);

    // ROL 21 by 2 with cf=0
    issue(ROL, 6'h21, 6'd2);
    for (int i = 1; i <= 2; i++) begin
      check($sformatf("rol2.rdy_T%0d", i), in_ready, 1'b0);
      check($sformatf("rol2.ov_T%0d", i), out_valid, 1'b0);
      check($sformatf("rol2.r_hold_T%0d", i), r, 6'h02);
      tick();
    end
    check_res("rol2", 6'h05, 1'b0, 1'b0, 1'b0);
    check("rol2.rdy_done", in_ready, 1'b1);

    // ROL clamp b=9 -> 6 steps; in_valid during ROT ignored
    issue(ROL, 6'h3F, 6'd9);
    in_valid = 1'b1; op = ZERO6; a = 6'h00; b = 6'h00;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) in_valid = 1'b0;
      check($sformatf("rol9.rdy_T%0d", i), in_ready, 1'b0);
      check($sformatf("rol9.ov_T%0d", i), out_valid, 1'b0);
      tick();
    end
    check_res("rol9", 6'h1F, 1'b1, 1'b0, 1'b0);
    tick();
    check("rol9.no_extra_ov", out_valid, 1'b0);
    check("rol9.ignored_in", r, 6'h1F);

    // OR then AND back to back
    in_valid = 1'b1; op = OR_; a = 6'h0A; b = 6'h05;
    tick();
    check_res("or", 6'h0F, 1'b0, 1'b0, 1'b0);
    op = AND_; a = 6'h0F; b = 6'h30;
    tick();
    in_valid = 1'b0;
    check_res("and", 6'h00, 1'b0, 1'b0, 1'b1);

    issue(XOR_, 6'h3C, 6'h0F);
    check_res("xor", 6'h33, 1'b0, 1'b1, 1'b0);

    // ZERO clears cf and reports zf=0
    issue(SUB, 6'h00, 6'h01);
    check_res("sub_neg", 6'h3F, 1'b1, 1'b1, 1'b0);
    issue(ZERO7, 6'h2A, 6'h15);
    check_res("zero", 6'h00, 1'b0, 1'b0, 1'b0);

    // ROL N=0 is single-cycle and keeps cf
    issue(SUB, 6'h00, 6'h01);
    issue(ROL, 6'h2A, 6'd0);
    check_res("rol0", 6'h2A, 1'b1, 1'b1, 1'b0);
    check("rol0.rdy", in_ready, 1'b1);

    // ROL N=1 pulls cf=1 into bit 0
    issue(ROL, 6'h00, 6'd1);
    check("rol1.ov_T1", out_valid, 1'b0);
    tick();
    check_res("rol1", 6'h01, 1'b0, 1'b0, 1'b0);

    // Reset during ROL discards it
    issue(SUB, 6'h00, 6'h01);
    issue(ROL, 6'h15, 6'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rot.r", r, 6'h00);
    check("rst_rot.flags", {cf, sf, zf}, 3'b000);
    check("rst_rot.rdy", in_ready, 1'b1);
    check("rst_rot.ov", out_valid, 1'b0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      check("rst_rot.no_late_ov", seen, 1'b0);
    end

`ifdef ALU_OVF_EN
    issue(ADD, 6'h1F, 6'h01);
    check_res("ovf_add", 6'h20, 1'b0, 1'b1, 1'b0);
    check("ovf_add.vf", vf, 1'b1);
    issue(SUB, 6'h20, 6'h01);
    check("ovf_sub.r", r, 6'h1F);
    check("ovf_sub.vf", vf, 1'b1);
    issue(OR_, 6'h01, 6'h02);
    check("ovf_or.vf", vf, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
